// File: rtl/timer_counter_core.sv
// Purpose: 8-bit timer/counter with prescaler, up or up/down counting, two compare
//          matches, a compare/PWM output and a level interrupt.
// Latency: count and overflow update on the tick edge; match_x one clk later; irq one clk after its inputs.
// Backpressure: none; every tick is consumed in the cycle it occurs.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   start                          counter enable (also releases the prescaler)
//   count_mode                     0 = up, 1 = up/down
//   clock_select, edge_mode        source select (clk / tmr_in edges) and external edge polarity
//   prescaler[2:0]                 divide source events by 2^prescaler
//   force_free                     run over 0..255 instead of count_min..count_max
//   count_init/min/max[7:0]        load value, lower limit, upper limit
//   cnt_init_wr                    one-cycle load strobe
//   match_0_value, match_1_value   compare values
//   pwm_mode, inv                  output mode, output inversion
//   *_int_en, *_status_flag        interrupt enables and sticky flags
//   tmr_in                         asynchronous external count input
//   count[7:0]                     current counter value
//   overflow, match_0, match_1     single-cycle event pulses
//   tmr_out, irq                   compare/PWM output, level interrupt
module timer_counter_core #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       count_mode,
    input  logic       clock_select,
    input  logic       edge_mode,
    input  logic [2:0] prescaler,
    input  logic       force_free,
    input  logic [7:0] count_init,
    input  logic [7:0] count_min,
    input  logic [7:0] count_max,
    input  logic       cnt_init_wr,
    input  logic [7:0] match_0_value,
    input  logic [7:0] match_1_value,
    input  logic       pwm_mode,
    input  logic       inv,
    input  logic       overflow_int_en,
    input  logic       out_match_0_int_en,
    input  logic       out_match_1_int_en,
    input  logic       overflow_status_flag,
    input  logic       cnt_match_0_status_flag,
    input  logic       cnt_match_1_status_flag,
    input  logic       tmr_in,
    output logic [7:0] count,
    output logic       overflow,
    output logic       match_0,
    output logic       match_1,
    output logic       tmr_out,
    output logic       irq
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // ------------------------------------------------------------------
    // External input synchroniser and edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sync_val;
    logic                   edge_evt;
    logic                   src_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tmr_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];
    assign edge_evt = edge_mode ? (hist_q & ~sync_val) : (~hist_q & sync_val);
    assign src_evt  = clock_select ? edge_evt : 1'b1;

    // ------------------------------------------------------------------
    // Prescaler: terminal value is 2^prescaler-1, built as a right-shifted
    // all-ones mask so prescaler=7 gives 127 without an 8-bit intermediate.
    // ------------------------------------------------------------------
    logic [6:0] psc_q;
    logic [6:0] psc_term;
    logic       tick;

    assign psc_term = 7'h7F >> (3'd7 - prescaler);
    assign tick     = start & src_evt & (psc_q == psc_term);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q <= '0;
        end else if (!start || cnt_init_wr) begin
            psc_q <= '0;
        end else if (src_evt) begin
            psc_q <= (psc_q == psc_term) ? 7'd0 : psc_q + 7'd1;
        end
    end

    // ------------------------------------------------------------------
    // Counter and direction: next-state logic
    // ------------------------------------------------------------------
    logic [7:0] count_q;
    logic [7:0] cnt_nxt;
    dir_t       dir_q;
    dir_t       dir_nxt;
    logic       ovf_nxt;
    logic       upd_nxt;
    logic [7:0] lo;
    logic [7:0] hi;

    assign lo = force_free ? 8'd0   : count_min;
    assign hi = force_free ? 8'd255 : count_max;

    always_comb begin
        cnt_nxt = count_q;
        dir_nxt = dir_q;
        ovf_nxt = 1'b0;
        upd_nxt = 1'b0;
        if (cnt_init_wr) begin
            // Load wins; a coincident tick is dropped entirely.
            cnt_nxt = count_init;
            dir_nxt = DIR_UP;
        end else if (tick) begin
            upd_nxt = 1'b1;
            if (lo >= hi) begin
                // Degenerate window: pin to lo and report every tick.
                cnt_nxt = lo;
                dir_nxt = DIR_UP;
                ovf_nxt = 1'b1;
            end else if (!count_mode) begin
                if (count_q >= hi) begin
                    cnt_nxt = lo;
                    ovf_nxt = 1'b1;
                end else begin
                    cnt_nxt = count_q + 8'd1;
                end
            end else if (dir_q == DIR_UP) begin
                if (count_q >= hi) begin
                    cnt_nxt = count_q - 8'd1;
                    dir_nxt = DIR_DOWN;
                    ovf_nxt = 1'b1;
                end else begin
                    cnt_nxt = count_q + 8'd1;
                end
            end else begin
                if (count_q <= lo) begin
                    cnt_nxt = count_q + 8'd1;
                    dir_nxt = DIR_UP;
                end else begin
                    cnt_nxt = count_q - 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Counter state, event pulses, output and interrupt registers
    // ------------------------------------------------------------------
    logic upd_q;    // count changed by a tick on the previous edge
    logic out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= 8'd0;
            dir_q    <= DIR_UP;
            overflow <= 1'b0;
            upd_q    <= 1'b0;
            match_0  <= 1'b0;
            match_1  <= 1'b0;
            out_q    <= 1'b0;
            irq      <= 1'b0;
        end else begin
            count_q  <= cnt_nxt;
            dir_q    <= dir_nxt;
            overflow <= ovf_nxt;
            upd_q    <= upd_nxt;
            // Compare the freshly ticked value; loads never set upd_q.
            match_0  <= upd_q & (count_q == match_0_value);
            match_1  <= upd_q & (count_q == match_1_value);
            if (pwm_mode) begin
                out_q <= (count_q < match_0_value);
            end else if (match_0) begin
                out_q <= ~out_q;
            end
            irq <= (overflow_status_flag    & overflow_int_en)
                 | (cnt_match_0_status_flag & out_match_0_int_en)
                 | (cnt_match_1_status_flag & out_match_1_int_en);
        end
    end

    assign count   = count_q;
    assign tmr_out = out_q ^ inv;

endmodule

// File: tb/tb_timer_counter_core.sv
module tb_timer_counter_core;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, count_mode, clock_select, edge_mode, force_free;
    logic [2:0] prescaler;
    logic [7:0] count_init, count_min, count_max, match_0_value, match_1_value;
    logic       cnt_init_wr, pwm_mode, inv;
    logic       overflow_int_en, out_match_0_int_en, out_match_1_int_en;
    logic       overflow_status_flag, cnt_match_0_status_flag, cnt_match_1_status_flag;
    logic       tmr_in;
    logic [7:0] count;
    logic       overflow, match_0, match_1, tmr_out, irq;

    int n_checks = 0;
    int n_fail   = 0;

    timer_counter_core #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .start(start), .count_mode(count_mode),
        .clock_select(clock_select), .edge_mode(edge_mode), .prescaler(prescaler),
        .force_free(force_free), .count_init(count_init), .count_min(count_min),
        .count_max(count_max), .cnt_init_wr(cnt_init_wr),
        .match_0_value(match_0_value), .match_1_value(match_1_value),
        .pwm_mode(pwm_mode), .inv(inv), .overflow_int_en(overflow_int_en),
        .out_match_0_int_en(out_match_0_int_en), .out_match_1_int_en(out_match_1_int_en),
        .overflow_status_flag(overflow_status_flag),
        .cnt_match_0_status_flag(cnt_match_0_status_flag),
        .cnt_match_1_status_flag(cnt_match_1_status_flag),
        .tmr_in(tmr_in), .count(count), .overflow(overflow), .match_0(match_0),
        .match_1(match_1), .tmr_out(tmr_out), .irq(irq)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: tmr_in seen SYNC edges late, source events counted
    // up to 2^prescaler, counter rules applied on plain integers.
    // ------------------------------------------------------------------
    int m_count;
    bit m_down;
    int m_ev;
    bit m_samp [0:3];
    bit m_upd, m_ovf, m_m0, m_m1, m_outq, m_irq;
    int mv_lo, mv_hi, mv_count;
    bit mv_now, mv_prev, mv_src, mv_tick, mv_down, mv_ovf, mv_upd, mv_m0, mv_m1, mv_outq, mv_irq;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count = 0; m_down = 0; m_ev = 0;
            for (int i = 0; i < 4; i++) m_samp[i] = 0;
            m_upd = 0; m_ovf = 0; m_m0 = 0; m_m1 = 0; m_outq = 0; m_irq = 0;
        end else begin
            mv_now  = m_samp[SYNC-1];
            mv_prev = m_samp[SYNC];
            mv_src  = clock_select ? (edge_mode ? (mv_prev && !mv_now) : (!mv_prev && mv_now)) : 1'b1;
            mv_tick = 0;
            if (!start || cnt_init_wr) m_ev = 0;
            else if (mv_src) begin
                if (m_ev + 1 == (1 << prescaler)) begin mv_tick = 1; m_ev = 0; end
                else m_ev = m_ev + 1;
            end
            mv_m0   = m_upd && (m_count == int'(match_0_value));
            mv_m1   = m_upd && (m_count == int'(match_1_value));
            mv_outq = pwm_mode ? (m_count < int'(match_0_value)) : (m_m0 ? !m_outq : m_outq);
            mv_irq  = (overflow_status_flag && overflow_int_en) ||
                      (cnt_match_0_status_flag && out_match_0_int_en) ||
                      (cnt_match_1_status_flag && out_match_1_int_en);
            mv_lo = force_free ? 0 : int'(count_min);
            mv_hi = force_free ? 255 : int'(count_max);
            mv_count = m_count; mv_down = m_down; mv_ovf = 0; mv_upd = 0;
            if (cnt_init_wr) begin
                mv_count = int'(count_init); mv_down = 0;
            end else if (mv_tick) begin
                mv_upd = 1;
                if (mv_lo >= mv_hi) begin
                    mv_count = mv_lo; mv_down = 0; mv_ovf = 1;
                end else if (!count_mode) begin
                    if (m_count >= mv_hi) begin mv_count = mv_lo; mv_ovf = 1; end
                    else mv_count = (m_count + 1) % 256;
                end else if (!m_down) begin
                    if (m_count >= mv_hi) begin mv_count = (m_count + 255) % 256; mv_down = 1; mv_ovf = 1; end
                    else mv_count = (m_count + 1) % 256;
                end else begin
                    if (m_count <= mv_lo) begin mv_count = (m_count + 1) % 256; mv_down = 0; end
                    else mv_count = (m_count + 255) % 256;
                end
            end
            for (int i = 3; i > 0; i--) m_samp[i] = m_samp[i-1];
            m_samp[0] = tmr_in;
            m_count = mv_count; m_down = mv_down; m_ovf = mv_ovf; m_upd = mv_upd;
            m_m0 = mv_m0; m_m1 = mv_m1; m_outq = mv_outq; m_irq = mv_irq;
        end
    end

    // Load strobe for one cycle; returns just after the load edge (on a negedge).
    task automatic do_load(input logic [7:0] v);
        count_init  = v;
        cnt_init_wr = 1'b1;
        @(negedge clk);
        cnt_init_wr = 1'b0;
    endtask

    task automatic pulse_tmr_in();
        tmr_in = 1'b1;
        repeat (4) @(negedge clk);
        tmr_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (count !== 8'd0)  begin n_fail++; $display("FAIL reset_count: got %0h expected 0", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        n_checks++; if (match_0 !== 1'b0 || match_1 !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %0b%0b expected 00", match_0, match_1); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0b expected 0", irq); end
        n_checks++; if (tmr_out !== 1'b0) begin n_fail++; $display("FAIL reset_tmr_out: got %0b expected 0", tmr_out); end
        @(negedge clk);
        rst = 1'b0;
        inv = 1'b1;
        #1;
        n_checks++; if (tmr_out !== 1'b1) begin n_fail++; $display("FAIL reset_tmr_out_inv: got %0b expected 1", tmr_out); end
        @(negedge clk);
        n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL idle_count: got %0h expected 0", count); end
        inv = 1'b0;
    endtask

    task automatic test_up_count();
        int  exp_c [6];
        bit  exp_o [6];
        exp_c = '{0, 1, 2, 3, 0, 1};
        exp_o = '{0, 0, 0, 0, 1, 0};
        clock_select = 0; prescaler = 0; count_mode = 0; force_free = 0;
        count_min = 0; count_max = 3; start = 1;
        do_load(8'd0);
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (count !== 8'(exp_c[i])) begin n_fail++; $display("FAIL up_count[%0d]: got %0d expected %0d", i, count, exp_c[i]); end
            n_checks++; if (overflow !== exp_o[i]) begin n_fail++; $display("FAIL up_overflow[%0d]: got %0b expected %0b", i, overflow, exp_o[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_ext_prescale();
        clock_select = 1; edge_mode = 0; prescaler = 2; force_free = 1; count_mode = 0;
        tmr_in = 0; start = 1;
        do_load(8'd10);
        repeat (8) pulse_tmr_in();
        n_checks++; if (count !== 8'd12) begin n_fail++; $display("FAIL ext_8_edges: got %0d expected 12", count); end
        // Three more rising edges leave the prescaler one short; the
        // falling edge of the last pulse must not complete it.
        repeat (3) pulse_tmr_in();
        n_checks++; if (count !== 8'd12) begin n_fail++; $display("FAIL ext_falling_no_tick: got %0d expected 12", count); end
        pulse_tmr_in();
        n_checks++; if (count !== 8'd13) begin n_fail++; $display("FAIL ext_next_rise: got %0d expected 13", count); end
    endtask

    task automatic test_updown();
        int exp_c [8];
        bit exp_o [8];
        exp_c = '{2, 3, 4, 5, 4, 3, 2, 3};
        exp_o = '{0, 0, 0, 0, 1, 0, 0, 0};
        clock_select = 0; prescaler = 0; force_free = 0; count_mode = 1;
        count_min = 2; count_max = 5; start = 1;
        do_load(8'd2);
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (count !== 8'(exp_c[i])) begin n_fail++; $display("FAIL updown_count[%0d]: got %0d expected %0d", i, count, exp_c[i]); end
            n_checks++; if (overflow !== exp_o[i]) begin n_fail++; $display("FAIL updown_overflow[%0d]: got %0b expected %0b", i, overflow, exp_o[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_load_priority();
        clock_select = 0; prescaler = 0; count_mode = 0; force_free = 1; start = 1;
        match_0_value = 8'h80; match_1_value = 8'h80;
        do_load(8'hFE);
        @(negedge clk);
        n_checks++; if (count !== 8'hFF) begin n_fail++; $display("FAIL lp_pre: got %0h expected ff", count); end
        do_load(8'h80);   // coincides with a wrapping tick
        n_checks++; if (count !== 8'h80) begin n_fail++; $display("FAIL lp_load: got %0h expected 80", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL lp_no_overflow: got %0b expected 0", overflow); end
        @(negedge clk);
        n_checks++; if (count !== 8'h81) begin n_fail++; $display("FAIL lp_after: got %0h expected 81", count); end
        n_checks++; if (match_0 !== 1'b0 || match_1 !== 1'b0) begin n_fail++; $display("FAIL lp_no_match: got %0b%0b expected 00", match_0, match_1); end
        do_load(8'hFD);
        repeat (3) @(negedge clk);
        n_checks++; if (count !== 8'h00) begin n_fail++; $display("FAIL lp_wrap: got %0h expected 0", count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL lp_wrap_overflow: got %0b expected 1", overflow); end
    endtask

    task automatic test_pwm();
        bit exp;
        logic prev;
        int toggles;
        clock_select = 0; prescaler = 0; count_mode = 0; force_free = 0; start = 1;
        count_min = 0; count_max = 4; match_0_value = 2; match_1_value = 8'hFF;
        pwm_mode = 1; inv = 0;
        do_load(8'd0);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            exp = (((i - 1) % 5) < 2);
            if (i > 10) exp = !exp;
            n_checks++; if (tmr_out !== exp) begin n_fail++; $display("FAIL pwm_out[%0d]: got %0b expected %0b", i, tmr_out, exp); end
            if (i == 10) inv = 1;
        end
        pwm_mode = 0; inv = 0;
        #1 prev = tmr_out;
        toggles = 0;
        repeat (10) begin
            @(negedge clk);
            if (tmr_out !== prev) toggles++;
            prev = tmr_out;
        end
        n_checks++; if (toggles != 2) begin n_fail++; $display("FAIL toggle_count: got %0d expected 2", toggles); end
    endtask

    task automatic test_irq_reset();
        overflow_status_flag = 1; overflow_int_en = 1;
        #1;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_latency: got %0b expected 0", irq); end
        @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_overflow: got %0b expected 1", irq); end
        overflow_status_flag = 0; cnt_match_1_status_flag = 1; out_match_1_int_en = 0;
        @(negedge clk);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %0b expected 0", irq); end
        out_match_1_int_en = 1;
        @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_match1: got %0b expected 1", irq); end
        force_free = 1; count_mode = 0;
        repeat (20) @(negedge clk);
        #2 rst = 1;
        cnt_match_1_status_flag = 0;
        #1;
        n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0h expected 0", count); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_mid_irq: got %0b expected 0", irq); end
        n_checks++; if (tmr_out !== inv) begin n_fail++; $display("FAIL rst_mid_tmr_out: got %0b expected %0b", tmr_out, inv); end
        @(negedge clk);
        prescaler = 2; clock_select = 0; start = 1;
        rst = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++; if (count !== ((k == 4) ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL rst_first_tick[%0d]: got %0d expected %0d", k, count, (k == 4) ? 1 : 0); end
            n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_no_pulse[%0d]: got %0b expected 0", k, overflow); end
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 10; seg++) begin
            prescaler     = 3'($urandom_range(0, 3));
            clock_select  = 1'($urandom_range(0, 1));
            edge_mode     = 1'($urandom_range(0, 1));
            count_mode    = 1'($urandom_range(0, 1));
            force_free    = ($urandom_range(0, 3) == 0);
            count_min     = 8'($urandom_range(0, 20));
            count_max     = 8'($urandom_range(0, 40));
            match_0_value = 8'($urandom_range(0, 40));
            match_1_value = 8'($urandom_range(0, 40));
            start = 1;
            do_load(8'($urandom_range(0, 40)));
            for (int c = 0; c < 300; c++) begin
                n_checks++; if (count !== 8'(m_count)) begin n_fail++; $display("FAIL rnd_count s%0d c%0d: got %0d expected %0d", seg, c, count, m_count); end
                n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow s%0d c%0d: got %0b expected %0b", seg, c, overflow, m_ovf); end
                n_checks++; if (match_0 !== m_m0) begin n_fail++; $display("FAIL rnd_match_0 s%0d c%0d: got %0b expected %0b", seg, c, match_0, m_m0); end
                n_checks++; if (match_1 !== m_m1) begin n_fail++; $display("FAIL rnd_match_1 s%0d c%0d: got %0b expected %0b", seg, c, match_1, m_m1); end
                n_checks++; if (tmr_out !== (m_outq ^ inv)) begin n_fail++; $display("FAIL rnd_tmr_out s%0d c%0d: got %0b expected %0b", seg, c, tmr_out, m_outq ^ inv); end
                n_checks++; if (irq !== m_irq) begin n_fail++; $display("FAIL rnd_irq s%0d c%0d: got %0b expected %0b", seg, c, irq, m_irq); end
                if ($urandom_range(0, 2) == 0) tmr_in = ~tmr_in;
                start       = ($urandom_range(0, 15) != 0);
                cnt_init_wr = ($urandom_range(0, 49) == 0);
                count_init  = 8'($urandom_range(0, 40));
                if ($urandom_range(0, 39) == 0) inv = ~inv;
                if ($urandom_range(0, 39) == 0) pwm_mode = ~pwm_mode;
                overflow_status_flag    = 1'($urandom_range(0, 1));
                cnt_match_0_status_flag = 1'($urandom_range(0, 1));
                cnt_match_1_status_flag = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 19) == 0) overflow_int_en    = ~overflow_int_en;
                if ($urandom_range(0, 19) == 0) out_match_0_int_en = ~out_match_0_int_en;
                if ($urandom_range(0, 19) == 0) out_match_1_int_en = ~out_match_1_int_en;
                @(negedge clk);
            end
            cnt_init_wr = 0;
        end
    endtask

    initial begin
        rst = 1; start = 0; count_mode = 0; clock_select = 0; edge_mode = 0;
        prescaler = 0; force_free = 0; count_init = 0; count_min = 0; count_max = 0;
        cnt_init_wr = 0; match_0_value = 0; match_1_value = 0; pwm_mode = 0; inv = 0;
        overflow_int_en = 0; out_match_0_int_en = 0; out_match_1_int_en = 0;
        overflow_status_flag = 0; cnt_match_0_status_flag = 0; cnt_match_1_status_flag = 0;
        tmr_in = 0;
        test_reset();
        test_up_count();
        test_ext_prescale();
        test_updown();
        test_load_priority();
        test_pwm();
        test_irq_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
